convolution_coprocessor_logic_unit: RTL

//  Parametrised, handshaked bitwise logic engine for the convolution coprocessor datapath.
//  - ELEMENT mode: applies a selectable bitwise op to each incoming (A,B) word pair.
//  - REDUCE mode: masks each pair with AND, then folds a burst of masked words into one result.
//  - Runs bursts of programmable length between the operand stream and the result stream.

---
 rtl/convolution_coprocessor_logic_unit.sv | 134 +++++++++++++
 1 files changed

// File: rtl/convolution_coprocessor_logic_unit.sv
// Handshaked bitwise logic engine: per-beat element ops or an AND-masked fold over a burst.
// One output register serves both modes; done_o marks the final output handshake.
module convolution_coprocessor_logic_unit #(
  parameter  int WIDTH   = 16,
  parameter  int MAX_LEN = 16,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic [1:0]       op_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

  typedef struct packed {
    logic             mode;
    logic [1:0]       op;
    logic [LEN_W-1:0] len;
  } cfg_t;

  state_t           state_q;
  cfg_t             cfg_q;
  logic [LEN_W-1:0] cnt_q;
  logic [WIDTH-1:0] acc_q, result_q;
  logic             m_valid_q, done_q;

  logic [LEN_W-1:0] len_d;
  logic [WIDTH-1:0] acc_d, elem_d, ident_d;
  logic             s_hs, last_beat;

  function automatic logic [WIDTH-1:0] elem_op(input logic [1:0] op,
                                               input logic [WIDTH-1:0] a, b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return a & ~b;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] fold(input logic [1:0] op,
                                            input logic [WIDTH-1:0] acc, p);
    case (op)
      2'b00:   return acc & p;
      2'b01:   return acc | p;
      default: return acc ^ p;
    endcase
  endfunction

  assign len_d     = (len_i > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len_i;
  assign ident_d   = (op_i == 2'b00) ? '1 : '0;
  assign acc_d     = fold(cfg_q.op, acc_q, a_i & b_i);
  assign elem_d    = elem_op(cfg_q.op, a_i, b_i);
  assign last_beat = (cnt_q + LEN_W'(1)) == cfg_q.len;

  // REDUCE never stalls the input; ELEMENT accepts only when the output slot frees up.
  assign s_ready_o = (state_q == RUN) && (cfg_q.mode || !m_valid_q || m_ready_i);
  assign s_hs      = s_valid_i && s_ready_o;

  assign m_valid_o = m_valid_q;
  assign result_o  = result_q;
  assign busy_o    = (state_q != IDLE);
  // DRAIN/OUT only ever hold the final result, so its handshake ends the burst.
  assign done_o    = done_q ||
                     ((state_q == DRAIN || state_q == OUT) && m_valid_q && m_ready_i);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      cfg_q     <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      m_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start_i) begin
          cfg_q <= '{mode: mode_i, op: op_i, len: len_d};
          cnt_q <= '0;
          acc_q <= ident_d;
          if (len_d == '0) begin
            if (mode_i) begin
              result_q  <= (op_i == 2'b11) ? ~ident_d : ident_d;
              m_valid_q <= 1'b1;
              state_q   <= OUT;
            end else begin
              done_q <= 1'b1;
            end
          end else begin
            state_q <= RUN;
          end
        end
        RUN: if (!cfg_q.mode) begin
          if (s_hs) begin
            result_q  <= elem_d;
            m_valid_q <= 1'b1;
            cnt_q     <= cnt_q + LEN_W'(1);
            if (last_beat) state_q <= DRAIN;
          end else if (m_ready_i) begin
            m_valid_q <= 1'b0;
          end
        end else if (s_hs) begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + LEN_W'(1);
          if (last_beat) begin
            result_q  <= (cfg_q.op == 2'b11) ? ~acc_d : acc_d;
            m_valid_q <= 1'b1;
            state_q   <= OUT;
          end
        end
        DRAIN, OUT: if (m_ready_i) begin
          m_valid_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
